seg_scan_ctrl: RTL and testbench

//   Drives a 4-digit multiplexed common-anode 7-segment display as the source side of the
//     hex-to-segment decoder: emits the active-low digit select (bus_4) and the digit nibble (in_4).

---
 rtl/seg_scan_ctrl_pkg.sv | 12 +
 rtl/seg_scan_ctrl_if.sv | 21 ++
 rtl/seg_scan_div.sv | 31 +++
 rtl/seg_scan_ctrl.sv | 99 +++++++++
 tb/tb_seg_scan_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed 7-segment scanner.
package seg_pkg;

   localparam int NDIG = 4;
   localparam logic [3:0] DIG_OFF = 4'b1111;

   // Active-low one-hot select for a digit index; digit 0 is the rightmost
   function automatic logic [3:0] dig_sel(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bus: value/load/blanking control in, digit select and nibble out.
interface seg_scan_ctrl_if;

   logic [15:0] data_in;
   logic        load;
   logic        blank_lz;
   logic [3:0]  bus_4;
   logic [3:0]  in_4;
   logic        frame_done;

   modport master (
      output data_in, load, blank_lz,
      input  bus_4, in_4, frame_done
   );

   modport slave (
      input  data_in, load, blank_lz,
      output bus_4, in_4, frame_done
   );

endinterface

// File: rtl/seg_scan_div.sv
// Slot timer: counts clock cycles within one digit slot and flags the
// blanking window at the start of the slot and the last cycle of the slot.
module seg_scan_div #(
   parameter int DIV   = 50000,
   parameter int BLANK = 16
) (
   input  logic clk,
   input  logic rst,
   output logic slot_end,
   output logic in_blank
);

   localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [TW-1:0] tick;

   // Free-running slot counter, wraps after DIV cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         tick <= '0;
      end else if (tick == TW'(DIV - 1)) begin
         tick <= '0;
      end else begin
         tick <= tick + 1'b1;
      end
   end

   assign slot_end = (tick == TW'(DIV - 1));
   assign in_blank = (tick < TW'(BLANK));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin scanner for a 4-digit common-anode display. The shown value
// only changes at frame boundaries so one frame never mixes two values.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIV   = 50000,
   parameter int BLANK = 16
) (
   input  logic            clk,
   input  logic            rst,
   seg_scan_ctrl_if.slave  seg
);

   localparam int IW = $clog2(NDIG);

   logic [IW-1:0] idx;
   logic [15:0]   active;
   logic [15:0]   pending;
   logic          pend_valid;
   logic          slot_end;
   logic          in_blank;
   logic          boundary;
   logic          boundary_q;
   logic          lz_off;

   seg_scan_div #(
      .DIV   (DIV),
      .BLANK (BLANK)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .slot_end (slot_end),
      .in_blank (in_blank)
   );

   assign boundary = slot_end && (idx == IW'(NDIG - 1));

   // Digit index steps once per slot and wraps back to the rightmost digit
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
      end else if (slot_end) begin
         idx <= idx + 1'b1;
      end
   end

   // Shadow register: loads park in pending and move to active only at a frame boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         active     <= '0;
         pending    <= '0;
         pend_valid <= 1'b0;
      end else if (boundary) begin
         if (seg.load) begin
            active <= seg.data_in;
         end else if (pend_valid) begin
            active <= pending;
         end
         pend_valid <= 1'b0;
      end else if (seg.load) begin
         pending    <= seg.data_in;
         pend_valid <= 1'b1;
      end
   end

   // Leading-zero test: a digit is dark when it and every digit left of it are zero
   always_comb begin
      lz_off = 1'b0;
      if (seg.blank_lz) begin
         case (idx)
            2'd1:    lz_off = (active[15:4]  == 12'h000);
            2'd2:    lz_off = (active[15:8]  == 8'h00);
            2'd3:    lz_off = (active[15:12] == 4'h0);
            default: lz_off = 1'b0;
         endcase
      end
   end

   // Registered outputs; frame_done is delayed one extra cycle so it lines up
   // with the first output cycle of the new frame's digit 0 slot
   always_ff @(posedge clk) begin
      if (rst) begin
         seg.bus_4      <= DIG_OFF;
         seg.in_4       <= 4'h0;
         seg.frame_done <= 1'b0;
         boundary_q     <= 1'b0;
      end else begin
         boundary_q     <= boundary;
         seg.frame_done <= boundary_q;
         if (in_blank) begin
            seg.bus_4 <= DIG_OFF;
         end else begin
            seg.in_4  <= active[{idx, 2'b00} +: 4];
            seg.bus_4 <= lz_off ? DIG_OFF : dig_sel(idx);
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised and directed bench for seg_scan_ctrl against a cycle-count based
// reference model of the display scan.
module tb_seg_scan_ctrl;

   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = 4 * DIV;

   logic clk;
   logic rst;

   seg_scan_ctrl_if seg ();

   seg_scan_ctrl #(
      .DIV   (DIV),
      .BLANK (BLANK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .seg (seg)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          checks;
   int          errors;
   int          mn;
   logic [15:0] m_act;
   logic [15:0] m_pend;
   logic        m_pv;
   logic [3:0]  m_in4;
   logic        m_prev_bnd;
   logic        cur_blz;
   logic        watch_hex;
   int          seen_hex;

   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, predict outputs from the model, then compare
   task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] d, input logic blz);
      logic [3:0] e_bus;
      logic [3:0] e_in;
      logic       e_fd;
      int         t;
      int         g;
      logic       bnd;
      @(negedge clk);
      rst          = r;
      seg.load     = ld;
      seg.data_in  = d;
      seg.blank_lz = blz;
      if (r) begin
         e_bus = 4'hF;
         e_in  = 4'h0;
         e_fd  = 1'b0;
         mn = 0; m_act = '0; m_pend = '0; m_pv = 1'b0; m_prev_bnd = 1'b0;
      end else begin
         t   = mn % DIV;
         g   = (mn / DIV) % 4;
         bnd = ((mn % FRAME) == FRAME - 1);
         e_fd = m_prev_bnd;
         if (t < BLANK) begin
            e_bus = 4'hF;
            e_in  = m_in4;
         end else begin
            e_in  = 4'(m_act >> (4 * g));
            e_bus = (blz && g != 0 && (m_act >> (4 * g)) == 16'h0) ? 4'hF : ~(4'b0001 << g);
         end
         m_prev_bnd = bnd;
         if (bnd) begin
            if (ld) m_act = d;
            else if (m_pv) m_act = m_pend;
            m_pv = 1'b0;
         end else if (ld) begin
            m_pend = d;
            m_pv   = 1'b1;
         end
         mn++;
      end
      m_in4 = e_in;
      @(posedge clk);
      #1;
      checkOutput("bus_4", {12'h0, seg.bus_4}, {12'h0, e_bus});
      checkOutput("in_4", {12'h0, seg.in_4}, {12'h0, e_in});
      checkOutput("frame_done", {15'h0, seg.frame_done}, {15'h0, e_fd});
      if (watch_hex && seg.bus_4 != 4'hF && seg.in_4 >= 4'hA) seen_hex++;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) applyStimulus(1'b0, 1'b0, 16'h0, cur_blz);
   endtask

   // Advance until the next cycle to execute is the first tick of a frame
   task automatic gotoFrameStart();
      for (int k = 0; k < FRAME && (mn % FRAME) != 0; k++) idle(1);
   endtask

   // Advance until the next cycle to execute is the frame boundary
   task automatic gotoBoundary();
      for (int k = 0; k < FRAME && (mn % FRAME) != FRAME - 1; k++) idle(1);
   endtask

   // Directed scenarios, then a long randomised run
   initial begin
      checks = 0; errors = 0; cur_blz = 1'b0; watch_hex = 1'b0; seen_hex = 0;
      mn = 0; m_act = '0; m_pend = '0; m_pv = 1'b0; m_in4 = 4'h0; m_prev_bnd = 1'b0;
      rst = 1'b1; seg.load = 1'b0; seg.data_in = '0; seg.blank_lz = 1'b0;

      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
      checkOutput("rst_bus", {12'h0, seg.bus_4}, 16'h000F);
      checkOutput("rst_in", {12'h0, seg.in_4}, 16'h0000);
      idle(FRAME + 4);

      gotoFrameStart();
      idle(5);
      applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
      gotoBoundary();
      idle(1);
      idle(1);
      checkOutput("scan_fd", {15'h0, seg.frame_done}, 16'h0001);
      idle(BLANK);
      checkOutput("scan_d0_sel", {12'h0, seg.bus_4}, 16'h000E);
      checkOutput("scan_d0_val", {12'h0, seg.in_4}, 16'h0004);
      idle(DIV);
      checkOutput("scan_d1_val", {12'h0, seg.in_4}, 16'h0003);
      gotoFrameStart();

      idle(4);
      applyStimulus(1'b0, 1'b1, 16'hABCD, 1'b0);
      watch_hex = 1'b1;
      idle(6);
      applyStimulus(1'b0, 1'b1, 16'h5678, 1'b0);
      idle(2 * FRAME);
      watch_hex = 1'b0;
      checkOutput("no_tear", 16'(seen_hex), 16'h0000);

      cur_blz = 1'b1;
      idle(3);
      applyStimulus(1'b0, 1'b1, 16'h0005, cur_blz);
      gotoBoundary();
      idle(1);
      idle(DIV + BLANK + 1);
      checkOutput("lz_d1_off", {12'h0, seg.bus_4}, 16'h000F);
      applyStimulus(1'b0, 1'b1, 16'h0000, cur_blz);
      idle(FRAME * 2);
      applyStimulus(1'b0, 1'b1, 16'h0100, cur_blz);
      idle(FRAME * 2);
      cur_blz = 1'b0;

      gotoBoundary();
      applyStimulus(1'b0, 1'b1, 16'h9876, cur_blz);
      idle(3 * DIV + BLANK + 1);
      checkOutput("bload_d3_sel", {12'h0, seg.bus_4}, 16'h0007);
      checkOutput("bload_d3_val", {12'h0, seg.in_4}, 16'h0009);
      idle(FRAME * 2);

      gotoFrameStart();
      idle(2 * DIV + BLANK + 1);
      applyStimulus(1'b1, 1'b0, 16'h0, cur_blz);
      checkOutput("mrst_bus", {12'h0, seg.bus_4}, 16'h000F);
      checkOutput("mrst_in", {12'h0, seg.in_4}, 16'h0000);
      idle(BLANK + 1);
      checkOutput("mrst_d0_sel", {12'h0, seg.bus_4}, 16'h000E);
      checkOutput("mrst_d0_val", {12'h0, seg.in_4}, 16'h0000);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 3) cur_blz = ~cur_blz;
         applyStimulus($urandom_range(0, 399) == 0,
                       $urandom_range(0, 5) == 0,
                       16'($urandom) & ($urandom_range(0, 1) ? 16'hFFFF : 16'h00FF),
                       cur_blz);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
